// File: rtl/ereg_execute.sv
// Execute stage: E pipeline register, single-cycle ALU, HI/LO and an
// iterative radix-2 restoring divider with a busy request for the hazard unit.
module ereg_execute #(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        E_stall,
  input  logic        E_bubble,
  input  logic        exception,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_val1,
  input  logic [31:0] d_val2,
  input  logic [31:0] d_valt,
  input  logic [5:0]  d_icode,
  input  logic [5:0]  d_acode,
  input  logic [5:0]  d_excCode,
  input  logic [4:0]  d_dst,
  input  logic        d_inDelaySlot,
  output logic [31:0] e_pc,
  output logic [31:0] e_val3,
  output logic [31:0] e_valt,
  output logic [5:0]  e_icode,
  output logic [5:0]  e_acode,
  output logic [5:0]  e_excCode,
  output logic [4:0]  e_dst,
  output logic        e_inDelaySlot,
  output logic        e_isLoad,
  output logic        e_busy,
  output logic [31:0] e_hi,
  output logic [31:0] e_lo
);

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_COP0     = 6'h10;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_LHU      = 6'h25;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;
  // SPECIAL function codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;
  // REGIMM link branches (rt field carried in acode), SPECIAL2 MUL
  localparam logic [5:0] RT_BLTZAL = 6'h10;
  localparam logic [5:0] RT_BGEZAL = 6'h11;
  localparam logic [5:0] F2_MUL    = 6'h02;
  // Exception codes (bit5 = valid)
  localparam logic [5:0] EXC_OVF  = 6'b101100;
  localparam logic [5:0] EXC_ADEL = 6'b100100;
  localparam logic [5:0] EXC_ADES = 6'b100101;

  localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

  // Two's-complement negate when neg is set; used for |x| and the sign fix
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  logic [31:0] pc_q, val1_q, val2_q, valt_q;
  logic [5:0]  icode_q, acode_q, exc_q;
  logic [4:0]  dst_q;
  logic        ds_q;
  logic [31:0] hi_q, lo_q;

  div_state_t  state_q;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic        qneg_q, rneg_q, kill_q;

  // E pipeline register: stall holds, bubble inserts a NOP, else capture decode
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q    <= '0;
      val1_q  <= '0;
      val2_q  <= '0;
      valt_q  <= '0;
      icode_q <= '0;
      acode_q <= '0;
      exc_q   <= '0;
      dst_q   <= '0;
      ds_q    <= 1'b0;
    end else if (E_stall) begin
      pc_q    <= pc_q;
    end else if (E_bubble) begin
      pc_q    <= '0;
      val1_q  <= '0;
      val2_q  <= '0;
      valt_q  <= '0;
      icode_q <= '0;
      acode_q <= '0;
      exc_q   <= '0;
      dst_q   <= '0;
      ds_q    <= 1'b0;
    end else begin
      pc_q    <= d_pc;
      val1_q  <= d_val1;
      val2_q  <= d_val2;
      valt_q  <= d_valt;
      icode_q <= d_icode;
      acode_q <= d_acode;
      exc_q   <= d_excCode;
      dst_q   <= d_dst;
      ds_q    <= d_inDelaySlot;
    end
  end

  logic is_r, is_mult, is_multu, is_div, is_divu, is_any_div, is_mthi, is_mtlo;
  assign is_r       = (icode_q == OP_SPECIAL);
  assign is_mult    = is_r && (acode_q == F_MULT);
  assign is_multu   = is_r && (acode_q == F_MULTU);
  assign is_div     = is_r && (acode_q == F_DIV);
  assign is_divu    = is_r && (acode_q == F_DIVU);
  assign is_any_div = is_div || is_divu;
  assign is_mthi    = is_r && (acode_q == F_MTHI);
  assign is_mtlo    = is_r && (acode_q == F_MTLO);

  logic [31:0]        sum, diff, link;
  logic [4:0]         shamt;
  logic signed [63:0] op1_s, op2_s, prod_s;
  logic [63:0]        prod_u;
  assign sum    = val1_q + val2_q;
  assign diff   = val1_q - val2_q;
  assign link   = val2_q + 32'd4;
  assign shamt  = val1_q[4:0];
  assign op1_s  = {{32{val1_q[31]}}, val1_q};
  assign op2_s  = {{32{val2_q[31]}}, val2_q};
  assign prod_s = op1_s * op2_s;
  assign prod_u = {32'd0, val1_q} * {32'd0, val2_q};

  logic [31:0] alu;
  // Single-cycle ALU on the latched operands
  always_comb begin
    alu = '0;
    case (icode_q)
      OP_SPECIAL: begin
        case (acode_q)
          F_ADD, F_ADDU:  alu = sum;
          F_SUB, F_SUBU:  alu = diff;
          F_AND:          alu = val1_q & val2_q;
          F_OR:           alu = val1_q | val2_q;
          F_XOR:          alu = val1_q ^ val2_q;
          F_NOR:          alu = ~(val1_q | val2_q);
          F_SLT:          alu = {31'd0, $signed(val1_q) < $signed(val2_q)};
          F_SLTU:         alu = {31'd0, val1_q < val2_q};
          F_SLL, F_SLLV:  alu = val2_q << shamt;
          F_SRL, F_SRLV:  alu = val2_q >> shamt;
          F_SRA, F_SRAV:  alu = $unsigned($signed(val2_q) >>> shamt);
          F_JALR:         alu = link;
          F_MFHI:         alu = hi_q;
          F_MFLO:         alu = lo_q;
          default:        alu = '0;
        endcase
      end
      OP_REGIMM: begin
        if (acode_q == RT_BGEZAL || acode_q == RT_BLTZAL) alu = link;
      end
      OP_JAL:                 alu = link;
      OP_ADDI, OP_ADDIU:      alu = sum;
      OP_SLTI:                alu = {31'd0, $signed(val1_q) < $signed(val2_q)};
      OP_SLTIU:               alu = {31'd0, val1_q < val2_q};
      OP_ANDI:                alu = val1_q & val2_q;
      OP_ORI:                 alu = val1_q | val2_q;
      OP_XORI:                alu = val1_q ^ val2_q;
      OP_LUI:                 alu = val2_q;
      OP_COP0: begin
        if (acode_q == 6'h00) alu = val1_q;
      end
      OP_SPECIAL2: begin
        if (acode_q == F2_MUL) alu = prod_s[31:0];
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW:    alu = sum;
      default:                alu = '0;
    endcase
  end

  logic ovf, ld_mis, st_mis, stage_exc;
  logic [5:0] exc_out;
  assign ovf = ((is_r && acode_q == F_ADD) || icode_q == OP_ADDI) ?
                 ((val1_q[31] == val2_q[31]) && (sum[31] != val1_q[31])) :
               (is_r && acode_q == F_SUB) ?
                 ((val1_q[31] != val2_q[31]) && (diff[31] != val1_q[31])) : 1'b0;
  assign ld_mis = ((icode_q == OP_LW) && (sum[1:0] != 2'b00)) ||
                  ((icode_q == OP_LH || icode_q == OP_LHU) && sum[0]);
  assign st_mis = ((icode_q == OP_SW) && (sum[1:0] != 2'b00)) ||
                  ((icode_q == OP_SH) && sum[0]);

  // An exception already carried in from earlier stages takes precedence
  always_comb begin
    exc_out = exc_q;
    if (!exc_q[5]) begin
      if (ovf)         exc_out = EXC_OVF;
      else if (ld_mis) exc_out = EXC_ADEL;
      else if (st_mis) exc_out = EXC_ADES;
    end
  end
  assign stage_exc = exc_out[5];

  logic [32:0] div_sh;
  logic        div_take;
  logic [31:0] rem_n, quo_n, quo_fix, rem_fix;
  assign div_sh   = {rem_q, quo_q[31]};
  assign div_take = (div_sh >= {1'b0, dvs_q});
  assign rem_n    = div_take ? (div_sh[31:0] - dvs_q) : div_sh[31:0];
  assign quo_n    = {quo_q[30:0], div_take};
  assign quo_fix  = neg_if(quo_q, qneg_q);
  assign rem_fix  = neg_if(rem_q, rneg_q);

  // Divider FSM. Any E advance or flush returns to IDLE; kill_q blocks a
  // restart of a flushed divide that is still held in E by a stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      kill_q  <= 1'b0;
    end else if (exception) begin
      state_q <= S_IDLE;
      kill_q  <= E_stall;
    end else if (!E_stall) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_any_div && !stage_exc && !kill_q) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= neg_if(val1_q, is_div && val1_q[31]);
            dvs_q   <= neg_if(val2_q, is_div && val2_q[31]);
            qneg_q  <= is_div && (val1_q[31] ^ val2_q[31]);
            rneg_q  <= is_div && val1_q[31];
          end
        end
        S_RUN: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // HI/LO commit when E advances with no flush and no stage exception
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!E_stall && !exception && !stage_exc) begin
      if (is_mult) begin
        {hi_q, lo_q} <= $unsigned(prod_s);
      end else if (is_multu) begin
        {hi_q, lo_q} <= prod_u;
      end else if (is_mthi) begin
        hi_q <= val1_q;
      end else if (is_mtlo) begin
        lo_q <= val1_q;
      end else if (is_any_div && state_q == S_DONE) begin
        lo_q <= quo_fix;
        hi_q <= rem_fix;
      end
    end
  end

  assign e_pc          = pc_q;
  assign e_val3        = alu;
  assign e_valt        = valt_q;
  assign e_icode       = icode_q;
  assign e_acode       = acode_q;
  assign e_excCode     = exc_out;
  assign e_dst         = stage_exc ? 5'd0 : dst_q;
  assign e_inDelaySlot = ds_q;
  assign e_isLoad      = (icode_q == OP_LB) || (icode_q == OP_LBU) || (icode_q == OP_LH) ||
                         (icode_q == OP_LHU) || (icode_q == OP_LW);
  assign e_busy        = is_any_div && (state_q != S_DONE) && !kill_q;
  assign e_hi          = hi_q;
  assign e_lo          = lo_q;

endmodule
